// File: rtl/wb_pkg.sv
// Shared widths and the queued-entry type for the write-back queue.
package wb_pkg;
   localparam int WB_DATA_W   = 32;
   localparam int WB_ADDR_W   = 4;
   localparam int WB_NUM_REGS = 16;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of write-back entries; also exposes every slot in age
// order (index 0 = head) with a valid bit, for the pending-mask and forwarding scans.
module wb_fifo
   import wb_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  wb_entry_t        entry_i,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [DEPTH-1:0] vld_o,
   output wb_entry_t        ent_o [DEPTH]
);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; slot contents are only trusted through vld_o.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= entry_i;
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         ent_o[k] = mem_q[rd_ptr_q + PTR_W'(k)];
         vld_o[k] = (CNT_W'(k) < count_q);
      end
   end

endmodule

// File: rtl/writeback_queue.sv
// Write-back queue in front of the 16x32 register file: FIFO, registered write port,
// pending-write mask. Define WB_FWD_EN to build the forwarding compare logic.
module writeback_queue
   import wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   ex_valid,
   output logic                   ex_ready,
   input  logic [ADDR_W-1:0]      ex_waddr,
   input  logic [DATA_W-1:0]      ex_data,
   input  logic                   wb_hold,
   output logic                   RegWr,
   output logic [ADDR_W-1:0]      Waddr,
   output logic [DATA_W-1:0]      Writedata,
   output logic [WB_NUM_REGS-1:0] pend,
   output logic                   busy,
   input  logic [ADDR_W-1:0]      q_addr1,
   input  logic [ADDR_W-1:0]      q_addr2,
   output logic                   fwd_hit1,
   output logic                   fwd_hit2,
   output logic [DATA_W-1:0]      fwd_data1,
   output logic [DATA_W-1:0]      fwd_data2
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   wb_entry_t        in_entry;
   wb_entry_t        ent [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full, fifo_empty;
   logic             push, pop;

   logic              reg_wr_q, reg_wr_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   assign in_entry.addr = ex_waddr;
   assign in_entry.data = ex_data;

   assign ex_ready = !fifo_full;
   assign push     = ex_valid && ex_ready;
   assign pop      = !fifo_empty && !wb_hold;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .push_i  (push),
      .pop_i   (pop),
      .entry_i (in_entry),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .vld_o   (vld),
      .ent_o   (ent)
   );

   always_comb begin
      reg_wr_d = pop;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      if (pop) begin
         waddr_d = ent[0].addr;
         wdata_d = ent[0].data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         reg_wr_q <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         reg_wr_q <= reg_wr_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign RegWr     = reg_wr_q;
   assign Waddr     = waddr_q;
   assign Writedata = wdata_q;
   assign busy      = (fifo_count != '0) || reg_wr_q;

   // The issuing write still counts as pending: the file only updates at negedge.
   always_comb begin
      pend = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (vld[k]) pend[ent[k].addr] = 1'b1;
      end
      if (reg_wr_q) pend[waddr_q] = 1'b1;
   end

`ifdef WB_FWD_EN
   // Output stage is the oldest value; later (younger) FIFO matches override it.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
      if (reg_wr_q && waddr_q == q_addr1) begin
         fwd_hit1  = 1'b1;
         fwd_data1 = wdata_q;
      end
      if (reg_wr_q && waddr_q == q_addr2) begin
         fwd_hit2  = 1'b1;
         fwd_data2 = wdata_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (vld[k] && ent[k].addr == q_addr1) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = ent[k].data;
         end
         if (vld[k] && ent[k].addr == q_addr2) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = ent[k].data;
         end
      end
   end
`else
   logic unused_q_addr;
   assign unused_q_addr = ^{q_addr1, q_addr2};
   assign fwd_hit1  = 1'b0;
   assign fwd_hit2  = 1'b0;
   assign fwd_data1 = '0;
   assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: accepted results are queued as expected
// writes, and a negedge monitor checks every RegWr cycle against them in order.
module tb_writeback_queue;
   import wb_pkg::*;

`ifdef WB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RESET;
   logic        ex_valid;
   logic        ex_ready;
   logic [3:0]  ex_waddr;
   logic [31:0] ex_data;
   logic        wb_hold;
   logic        RegWr;
   logic [3:0]  Waddr;
   logic [31:0] Writedata;
   logic [15:0] pend;
   logic        busy;
   logic [3:0]  q_addr1, q_addr2;
   logic        fwd_hit1, fwd_hit2;
   logic [31:0] fwd_data1, fwd_data2;

   writeback_queue #(.DEPTH(4)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .ex_valid  (ex_valid),
      .ex_ready  (ex_ready),
      .ex_waddr  (ex_waddr),
      .ex_data   (ex_data),
      .wb_hold   (wb_hold),
      .RegWr     (RegWr),
      .Waddr     (Waddr),
      .Writedata (Writedata),
      .pend      (pend),
      .busy      (busy),
      .q_addr1   (q_addr1),
      .q_addr2   (q_addr2),
      .fwd_hit1  (fwd_hit1),
      .fwd_hit2  (fwd_hit2),
      .fwd_data1 (fwd_data1),
      .fwd_data2 (fwd_data2)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]  a;
      logic [31:0] d;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] rf [16];
   int          n_chk  = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_wr(input logic [3:0] a, input logic [31:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   always @(negedge CLK) begin
      if (RegWr === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: Waddr=%0d data=0x%0h, none expected", Waddr, Writedata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wb_addr", 32'(Waddr), 32'(e.a));
            chk("wb_data", Writedata, e.d);
         end
         rf[Waddr] = Writedata;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET    = 1'b1;
      ex_valid = 1'b0;
      ex_waddr = '0;
      ex_data  = '0;
      wb_hold  = 1'b0;
      q_addr1  = '0;
      q_addr2  = '0;
      for (int i = 0; i < 16; i++) rf[i] = '0;

      repeat (2) tick();
      chk("rst_regwr", 32'(RegWr), 0);
      chk("rst_pend",  32'(pend), 0);
      chk("rst_ready", 32'(ex_ready), 1);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_waddr", 32'(Waddr), 0);
      chk("rst_wdata", Writedata, 0);
      RESET = 1'b0;

      // single push: pend one edge later, write one edge after that
      ex_valid = 1'b1; ex_waddr = 4'd3; ex_data = 32'h0000_00AA;
      chk("single_ready", 32'(ex_ready), 1);
      expect_wr(4'd3, 32'hAA);
      tick();
      ex_valid = 1'b0;
      chk("single_pend_q", 32'(pend), 32'h0008);
      chk("single_nobypass", 32'(RegWr), 0);
      tick();
      chk("single_regwr", 32'(RegWr), 1);
      chk("single_waddr", 32'(Waddr), 3);
      chk("single_wdata", Writedata, 32'hAA);
      chk("single_pend_iss", 32'(pend), 32'h0008);
      chk("single_busy", 32'(busy), 1);
      tick();
      chk("single_done_wr", 32'(RegWr), 0);
      chk("single_done_pend", 32'(pend), 0);
      chk("single_done_busy", 32'(busy), 0);
      chk("single_hold_wd", Writedata, 32'hAA);

      // fill under hold, then release while a fifth result is offered
      wb_hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         ex_valid = 1'b1; ex_waddr = 4'(i); ex_data = 32'h100 + 32'(i);
         expect_wr(4'(i), 32'h100 + 32'(i));
         tick();
      end
      ex_valid = 1'b0;
      chk("full_ready", 32'(ex_ready), 0);
      chk("full_pend", 32'(pend), 32'h001E);
      chk("full_busy", 32'(busy), 1);
      tick();
      chk("hold_nowr", 32'(RegWr), 0);
      ex_valid = 1'b1; ex_waddr = 4'd9; ex_data = 32'h999;
      wb_hold  = 1'b0;
      tick();
      ex_valid = 1'b0;
      chk("drain_wr0", 32'(RegWr), 1);
      chk("drain_ready", 32'(ex_ready), 1);
      chk("drain_pend", 32'(pend), 32'h001E);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("drain_wr", 32'(RegWr), 1);
      end
      tick();
      chk("drain_end_wr", 32'(RegWr), 0);
      chk("drain_end_pend", 32'(pend), 0);

      // same register twice: last write wins, pend spans both
      ex_valid = 1'b1; ex_waddr = 4'd5; ex_data = 32'h11;
      expect_wr(4'd5, 32'h11);
      tick();
      ex_data = 32'h22;
      expect_wr(4'd5, 32'h22);
      tick();
      ex_valid = 1'b0;
      chk("dup_pend1", 32'(pend), 32'h0020);
      tick();
      chk("dup_pend2", 32'(pend), 32'h0020);
      chk("dup_wd2", Writedata, 32'h22);
      tick();
      chk("dup_pend_clr", 32'(pend), 0);
      chk("dup_rf5", rf[5], 32'h22);

      // steady stream, one push per cycle
      for (int i = 0; i < 8; i++) begin
         ex_valid = 1'b1; ex_waddr = 4'(i + 8); ex_data = 32'h200 + 32'(i);
         expect_wr(4'(i + 8), 32'h200 + 32'(i));
         tick();
         chk("stream_ready", 32'(ex_ready), 1);
         if (i > 0) chk("stream_wr", 32'(RegWr), 1);
      end
      ex_valid = 1'b0;
      tick();
      chk("stream_last_wr", 32'(RegWr), 1);
      tick();
      chk("stream_idle_wr", 32'(RegWr), 0);
      chk("stream_idle_busy", 32'(busy), 0);

      // forwarding: younger FIFO entry beats output stage
      wb_hold = 1'b1;
      ex_valid = 1'b1; ex_waddr = 4'd7; ex_data = 32'h5;
      expect_wr(4'd7, 32'h5);
      tick();
      ex_data = 32'h9;
      expect_wr(4'd7, 32'h9);
      tick();
      ex_valid = 1'b0;
      q_addr1 = 4'd7; q_addr2 = 4'd8;
      #1;
      chk("fwd_hit1_q", 32'(fwd_hit1), FWD ? 1 : 0);
      chk("fwd_data1_q", fwd_data1, FWD ? 32'h9 : 32'h0);
      chk("fwd_hit2_miss", 32'(fwd_hit2), 0);
      chk("fwd_data2_miss", fwd_data2, 0);
      wb_hold = 1'b0;
      q_addr2 = 4'd7;
      tick();
      chk("fwd_prio_hit", 32'(fwd_hit2), FWD ? 1 : 0);
      chk("fwd_prio_data", fwd_data2, FWD ? 32'h9 : 32'h0);
      tick();
      chk("fwd_out_hit", 32'(fwd_hit1), FWD ? 1 : 0);
      chk("fwd_out_data", fwd_data1, FWD ? 32'h9 : 32'h0);
      tick();
      chk("fwd_gone", 32'(fwd_hit1), 0);

      // reset with a full queue discards everything
      wb_hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         ex_valid = 1'b1; ex_waddr = 4'(i); ex_data = 32'hA0 + 32'(i);
         expect_wr(4'(i), 32'hA0 + 32'(i));
         tick();
      end
      ex_valid = 1'b0;
      chk("pre_rst_ready", 32'(ex_ready), 0);
      RESET   = 1'b1;
      wb_hold = 1'b0;
      exp_q.delete();
      tick();
      RESET = 1'b0;
      chk("frst_regwr", 32'(RegWr), 0);
      chk("frst_pend", 32'(pend), 0);
      chk("frst_ready", 32'(ex_ready), 1);
      chk("frst_busy", 32'(busy), 0);
      repeat (4) tick();
      chk("frst_stale_wr", 32'(RegWr), 0);
      chk("frst_stale_busy", 32'(busy), 0);

      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Write-back stage sitting directly upstream of the 16x32 register file.
- Buffers results from execute in a small in-order FIFO and issues at most one register write per cycle on RegWr/Waddr/Writedata.
- Outputs are registered on posedge CLK, so they are stable when the file samples at negedge CLK.
- Exports a pending-write mask per register, used by decode for hazard stalls.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DATA_W, 32, result width; matches the register file.
- ADDR_W, 4, register address width (16 registers).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute result valid.
- ex_ready  out  1  queue can accept; combinational, equals (count < DEPTH).
- ex_waddr  in  ADDR_W  destination register.
- ex_data  in  DATA_W  result value.
- wb_hold  in  1  when 1, no write is issued this cycle.
- RegWr  out  1  write strobe to the register file (registered).
- Waddr  out  ADDR_W  write address (registered).
- Writedata  out  DATA_W  write data (registered).
- pend  out  16  bit r=1 while a write to register r is queued or being issued.
- busy  out  1  asserted when count != 0 or RegWr == 1.
- q_addr1, q_addr2  in  ADDR_W  forwarding query addresses.
- fwd_hit1, fwd_hit2  out  1  forwarding hit.
- fwd_data1, fwd_data2  out  DATA_W  forwarded value.

Behaviour:
- Reset (RESET=1 at posedge, synchronous):
  - count, rd_ptr and wr_ptr go to 0; RegWr=0, Waddr=0, Writedata=0.
  - pend=0, busy=0, ex_ready=1.
  - Reset overrides push and pop in the same cycle. Queued entries are discarded, and a write in flight is dropped from the next cycle on.
- Push: at posedge with ex_valid && ex_ready, store {ex_waddr, ex_data} at wr_ptr; wr_ptr += 1 (mod DEPTH).
- Pop:
  - At posedge with count != 0 and wb_hold == 0: RegWr<=1, Waddr<=head.addr, Writedata<=head.data; rd_ptr += 1 (mod DEPTH).
  - Otherwise RegWr<=0, and Waddr/Writedata hold their values.
- Count update:
  - Push and pop in the same cycle leave count unchanged; the popped entry is the old head.
  - A push to an empty queue is never written the same cycle: no bypass.
- Latency: accept at posedge k, RegWr=1 during the cycle after posedge k+1, register file written at the following negedge. Minimum latency 1 cycle plus a half cycle.
- Full: count == DEPTH gives ex_ready=0, and ex_valid is ignored. A pop in that cycle does not enable a push in the same cycle.
- Empty: RegWr=0 on the next edge. wb_hold has no effect.
- Order: writes issue strictly in acceptance order. Repeated writes to the same register are all issued, and the last one wins.
- Pointer wrap: modulo DEPTH; count is ADDR-independent and $clog2(DEPTH)+1 bits wide.
- pend (combinational): pend[r] = OR over valid entries of (addr == r) OR (RegWr && Waddr == r).
  - Covers the issuing cycle, because the file updates only at negedge.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - fwd_hitN=1 when q_addrN matches a valid FIFO entry or the issuing output stage.
  - fwd_dataN = value of the youngest match. Priority runs from the newest FIFO entry to the oldest, then the output stage.
  - Hazard logic may then bypass rather than stall.
- Undefined: ports remain present, with fwd_hitN=0 and fwd_dataN=0; no compare logic is built.

Decomposition:
- Package wb_pkg holds:
  - WB_DATA_W=32, WB_ADDR_W=4, WB_NUM_REGS=16.
  - typedef wb_entry_t {addr, data}.
- Sub-module wb_fifo: circular buffer with push/pop/count/full/empty, plus a per-entry valid/contents view for pend and forwarding scans.
- writeback_queue instantiates wb_fifo and adds the output register, pend and forwarding logic.

Test Plan:
- Reset with queue full (4 entries) -> next cycle RegWr=0, pend=0, ex_ready=1, busy=0; no stale writes afterwards.
- Single push {r3, 0x0000_00AA} on an empty queue -> pend[3]=1 one edge later; RegWr=1, Waddr=3, Writedata=0xAA one edge after that; pend[3] clears after that cycle.
- Four back-to-back pushes with wb_hold=1 -> ex_ready=0, and a fifth ex_valid is ignored. Release hold -> four consecutive RegWr cycles in order r1, r2, r3, r4.
- Push r5=0x11 then r5=0x22 -> two writes in order; final file value 0x22; pend[5] stays 1 until the second write's cycle ends.
- Steady stream, one push per cycle with no hold -> count never exceeds 1, ex_ready stays 1, and RegWr=1 every cycle after the first.
- WB_FWD_EN defined: queue holds r7=0x5, r7=0x9; q_addr1=7 -> fwd_hit1=1, fwd_data1=0x9. Query q_addr2=8 -> fwd_hit2=0. Macro undefined -> both hits 0.
